// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the integer register file: picks one of ALU/LSU per
// cycle, registers the write port and keeps a pending-write scoreboard.
module rf_wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = $clog2(STARVE_LIMIT+1)
) (
   input  logic        Wr_Clk,
   input  logic        Rst_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        lsu_valid,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        lsu_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic [31:0] busy,
   output logic        RegWr,
   output logic [4:0]  Rw,
   output logic [31:0] busW
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             regwr_q, regwr_d;
   logic [4:0]       rw_q, rw_d;
   logic [31:0]      busw_q, busw_d;
   logic [31:0]      busy_q, busy_d;

   logic        starved, alu_xfer, lsu_xfer;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data, set_vec, clr_vec;

   // LSU has default priority; a starved ALU takes the port for one transfer.
   assign starved   = (cnt_q == CNT_W'(STARVE_LIMIT));
   assign lsu_ready = !(alu_valid && starved);
   assign alu_ready = !lsu_valid || starved;
   assign alu_xfer  = alu_valid && alu_ready;
   assign lsu_xfer  = lsu_valid && lsu_ready;

   always_comb begin
      cnt_d = cnt_q;
      if (!alu_valid || alu_xfer)
         cnt_d = '0;
      else if (!starved)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_comb begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
      if (alu_xfer) begin
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end
   end

   // x0 transfers still handshake but never reach the register file.
   always_comb begin
      regwr_d = (alu_xfer || lsu_xfer) && (sel_rd != 5'd0);
      rw_d    = rw_q;
      busw_d  = busw_q;
      if (regwr_d) begin
         rw_d   = sel_rd;
         busw_d = sel_data;
      end
   end

   // A same-edge set overrides the retiring clear so the younger writer is tracked.
   always_comb begin
      set_vec = issue_valid ? (32'h1 << issue_rd) : 32'h0;
      clr_vec = regwr_q ? (32'h1 << rw_q) : 32'h0;
      busy_d  = ((busy_q & ~clr_vec) | set_vec) & ~32'h1;
   end

   always_ff @(posedge Wr_Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q   <= '0;
         regwr_q <= 1'b0;
         rw_q    <= 5'd0;
         busw_q  <= 32'h0;
         busy_q  <= 32'h0;
      end else begin
         cnt_q   <= cnt_d;
         regwr_q <= regwr_d;
         rw_q    <= rw_d;
         busw_q  <= busw_d;
         busy_q  <= busy_d;
      end
   end

   assign RegWr = regwr_q;
   assign Rw    = rw_q;
   assign busW  = busw_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a reference model predicts grants,
// queues expected register writes and tracks the pending-write bits.
module tb_rf_wb_arbiter;
   localparam int STARVE_LIMIT = 4;

   logic        Wr_Clk = 1'b0;
   logic        Rst_n;
   logic        alu_valid, lsu_valid, issue_valid;
   logic [4:0]  alu_rd, lsu_rd, issue_rd;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready, RegWr;
   logic [4:0]  Rw;
   logic [31:0] busy, busW;

   rf_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .Wr_Clk(Wr_Clk), .Rst_n(Rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .busy(busy), .RegWr(RegWr), .Rw(Rw), .busW(busW)
   );

   always #5 Wr_Clk = ~Wr_Clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   int          errs = 0, checks = 0;
   int          m_cnt = 0;
   logic [31:0] m_busy = 0, m_busw = 0;
   logic [4:0]  m_rw = 0;
   wr_t         exp_q[$];
   bit          due = 0, last_v = 0;
   wr_t         last_w;
   bit          last_axf, last_lxf;
   int          step_no = 0;
   int          first_alu = -1, n_alu = 0;
   logic [31:0] tb_rf [32];

   // Register file stand-in: samples the write port on the falling edge.
   always @(negedge Wr_Clk)
      if (RegWr) tb_rf[Rw] <= busW;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_busy = 0; m_rw = 0; m_busw = 0;
      exp_q.delete(); due = 0; last_v = 0;
   endtask

   task automatic quiet();
      alu_valid = 0; lsu_valid = 0; issue_valid = 0;
   endtask

   // Check this cycle at the falling edge, then advance the model over the next rising edge.
   task automatic step();
      bit st, lr, ar, axf, lxf;
      wr_t w;
      logic [31:0] clr;
      @(negedge Wr_Clk);
      st = (m_cnt == STARVE_LIMIT);
      lr = !(alu_valid && st);
      ar = !lsu_valid || st;
      chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, lr});
      chk("alu_ready", {31'b0, alu_ready}, {31'b0, ar});
      clr = 0;
      w = '0;
      if (due) begin
         w = exp_q.pop_front();
         m_rw = w.rd; m_busw = w.data;
         clr = 32'h1 << w.rd;
      end
      chk("RegWr", {31'b0, RegWr}, {31'b0, due});
      chk("Rw", {27'b0, Rw}, {27'b0, m_rw});
      chk("busW", busW, m_busw);
      chk("busy", busy, m_busy);
      if (last_v) chk("rf_read", tb_rf[last_w.rd], last_w.data);
      last_v = due;
      last_w = w;
      if (alu_valid && alu_ready) begin
         if (first_alu < 0) first_alu = step_no;
         n_alu++;
      end
      axf = alu_valid && ar;
      lxf = lsu_valid && lr;
      if (!alu_valid || axf) m_cnt = 0;
      else if (m_cnt < STARVE_LIMIT) m_cnt++;
      due = 0;
      if (axf && alu_rd != 0) begin exp_q.push_back('{alu_rd, alu_data}); due = 1; end
      else if (lxf && !axf && lsu_rd != 0) begin exp_q.push_back('{lsu_rd, lsu_data}); due = 1; end
      m_busy = ((m_busy & ~clr) | (issue_valid ? (32'h1 << issue_rd) : 32'h0)) & ~32'h1;
      last_axf = axf; last_lxf = lxf;
      step_no++;
      @(posedge Wr_Clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) tb_rf[i] = 0;
      // Reset with random inputs toggling.
      Rst_n = 0;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'($urandom); lsu_valid = 1'($urandom); issue_valid = 1'($urandom);
         alu_rd = 5'($urandom); lsu_rd = 5'($urandom); issue_rd = 5'($urandom);
         alu_data = $urandom; lsu_data = $urandom;
         @(posedge Wr_Clk); #1;
         chk("rst_RegWr", {31'b0, RegWr}, 32'h0);
         chk("rst_Rw", {27'b0, Rw}, 32'h0);
         chk("rst_busW", busW, 32'h0);
         chk("rst_busy", busy, 32'h0);
      end
      quiet();
      Rst_n = 1;

      // First write after reset.
      alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
      step(); quiet(); step();

      // x0 discard: handshake completes, port holds.
      lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD_BEEF;
      step(); quiet(); step(); step();

      // Scoreboard set, clear, and same-edge set/clear.
      issue_valid = 1; issue_rd = 7; step(); quiet();
      alu_valid = 1; alu_rd = 7; alu_data = 32'hA5A5_0007; step(); quiet();
      step(); step();
      issue_valid = 1; issue_rd = 7; step(); quiet();
      alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_0777; step(); quiet();
      issue_valid = 1; issue_rd = 7; step(); quiet();
      step();
      chk("busy7_same_edge", {31'b0, busy[7]}, 32'h1);
      alu_valid = 1; alu_rd = 7; alu_data = 32'h7777_0000; step(); quiet();
      step(); step();

      // Back-to-back LSU writes.
      for (int i = 1; i <= 3; i++) begin
         lsu_valid = 1; lsu_rd = 5'(i); lsu_data = 32'hB0B0_0000 + i; step();
      end
      quiet(); step(); step();

      // Pending issues plus contention, then reset mid-write with the counter saturated.
      alu_valid = 1; alu_rd = 20; alu_data = 32'hC0DE_0020;
      lsu_valid = 1; lsu_rd = 9;
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1; issue_rd = 5'(4 + i); lsu_data = 32'h9900_0000 + i;
         step();
      end
      quiet();
      #2;
      chk("pre_rst_RegWr", {31'b0, RegWr}, 32'h1);
      chk("pre_rst_busy", busy, 32'h0000_00F0);
      Rst_n = 0;
      #1;
      chk("async_RegWr", {31'b0, RegWr}, 32'h0);
      chk("async_Rw", {27'b0, Rw}, 32'h0);
      chk("async_busW", busW, 32'h0);
      chk("async_busy", busy, 32'h0);
      model_reset();
      @(posedge Wr_Clk); #3;
      Rst_n = 1;
      @(posedge Wr_Clk); #1;

      // Contention from a cleared counter: LSU x4 then ALU, repeating.
      first_alu = -1; n_alu = 0; step_no = 0;
      alu_valid = 1; alu_rd = 10; alu_data = 32'hA000_0000;
      lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hB000_0000;
      for (int i = 0; i < 10; i++) begin
         step();
         if (last_axf) begin alu_rd = 5'(alu_rd + 2); alu_data = alu_data + 1; end
         if (last_lxf) begin lsu_rd = 5'(lsu_rd + 2); lsu_data = lsu_data + 1; end
      end
      chk("first_alu_grant", first_alu, 4);
      chk("alu_grants", n_alu, 2);
      quiet(); step(); step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got stuck want finish");
      $fatal(1);
   end
endmodule
